// File: rtl/gray_ptr_rx_pkg.sv
// Shared types and helpers for the Gray-pointer receive side.
// Used by gray_ptr_rx; the width-generic helpers operate on a MAX_W-bit carrier.
package gray_ptr_rx_pkg;

   localparam int STEP_CNT_W = 16;
   localparam int MAX_W      = 32;

   typedef enum logic [1:0] {
      INIT,
      TRACK,
      FAULT
   } state_t;

   // Each binary bit is the parity of its own and all higher Gray bits.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                 input int width);
      logic [MAX_W-1:0] b;
      logic [MAX_W-1:0] m;
      m = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
      for (int i = 0; i < MAX_W; i++) begin
         b[i] = ^((g & m) >> i);
      end
      return b;
   endfunction

   function automatic int popcount(input logic [MAX_W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_W; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gray_ptr_rx_sync.sv
// Multi-flop synchroniser for a Gray-coded word, synchronous active-high reset to 0.
// Generic enough to be reused on the write side of an async FIFO.
module gray_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= '0;
         end
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray pointer crossing: synchronise, decode, track +1 advances, flag multi-bit jumps.
// Optional saturating step counter port when GRAY_PTR_RX_STEP_CNT_EN is defined.
module gray_ptr_rx
   import gray_ptr_rx_pkg::*;
#(
   parameter int SIZE        = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] gray_in,
   input  logic            err_clr,
   output logic [SIZE-1:0] bin_out,
   output logic [SIZE-1:0] gray_sync,
   output logic [SIZE-1:0] delta,
   output logic            step,
   output logic            valid,
   output logic            err
`ifdef GRAY_PTR_RX_STEP_CNT_EN
   ,
   output logic [STEP_CNT_W-1:0] step_cnt
`endif
);

   localparam int CNT_W = 3;

   logic [SIZE-1:0]  s;
   logic [SIZE-1:0]  s_bin;
   logic [SIZE-1:0]  diff;
   int               hd;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] warm_q, warm_n;
   logic [SIZE-1:0]  bin_q, bin_n;
   logic [SIZE-1:0]  gray_q, gray_n;
   logic [SIZE-1:0]  delta_q, delta_n;
   logic             step_q, step_n;
   logic             valid_q, valid_n;
   logic             err_q, err_n;

   gray_sync #(
      .WIDTH  (SIZE),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gray_in),
      .q   (s)
   );

   assign s_bin = SIZE'(gray2bin(MAX_W'(s), SIZE));
   assign hd    = popcount(MAX_W'(s ^ gray_q));
   assign diff  = s_bin - bin_q;

   // All visible outputs are registered together with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         warm_q  <= '0;
         bin_q   <= '0;
         gray_q  <= '0;
         delta_q <= '0;
         step_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         warm_q  <= warm_n;
         bin_q   <= bin_n;
         gray_q  <= gray_n;
         delta_q <= delta_n;
         step_q  <= step_n;
         valid_q <= valid_n;
         err_q   <= err_n;
      end
   end

   // INIT waits for the synchroniser to flush before taking a baseline;
   // a multi-bit jump while tracking is treated as a corrupted crossing.
   always_comb begin
      state_n = state_q;
      warm_n  = warm_q;
      bin_n   = bin_q;
      gray_n  = gray_q;
      delta_n = '0;
      step_n  = 1'b0;
      valid_n = valid_q;
      err_n   = err_q;
      case (state_q)
         INIT: begin
            valid_n = 1'b0;
            if (warm_q == CNT_W'(SYNC_STAGES)) begin
               gray_n  = s;
               bin_n   = s_bin;
               valid_n = 1'b1;
               state_n = TRACK;
            end else begin
               warm_n = warm_q + CNT_W'(1);
            end
         end
         TRACK: begin
            if (hd == 1) begin
               gray_n  = s;
               bin_n   = s_bin;
               delta_n = diff;
               step_n  = (diff == SIZE'(1));
            end else if (hd >= 2) begin
               err_n   = 1'b1;
               state_n = FAULT;
            end
         end
         FAULT: begin
            if (err_clr) begin
               err_n   = 1'b0;
               valid_n = 1'b0;
               warm_n  = '0;
               state_n = INIT;
            end
         end
         default: begin
            state_n = INIT;
            warm_n  = '0;
            valid_n = 1'b0;
         end
      endcase
   end

   assign bin_out   = bin_q;
   assign gray_sync = gray_q;
   assign delta     = delta_q;
   assign step      = step_q;
   assign valid     = valid_q;
   assign err       = err_q;

`ifdef GRAY_PTR_RX_STEP_CNT_EN
   logic [STEP_CNT_W-1:0] step_cnt_q;

   // Saturating count of step pulses; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_cnt_q <= '0;
      end else if (step_n && (step_cnt_q != '1)) begin
         step_cnt_q <= step_cnt_q + STEP_CNT_W'(1);
      end
   end

   assign step_cnt = step_cnt_q;
`endif

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Self-checking bench for gray_ptr_rx: directed plan scenarios followed by randomized Gray traffic.
// Acceptances are scored through a queue; per-cycle state is compared against a behavioural model.
module tb_gray_ptr_rx;

   localparam int SIZE = 4;
   localparam int SYNC = 2;
   localparam int NV   = 1 << SIZE;

   logic            clk = 1'b0;
   logic            rst;
   logic            err_clr;
   logic [SIZE-1:0] gray_in;
   logic [SIZE-1:0] bin_out;
   logic [SIZE-1:0] gray_sync;
   logic [SIZE-1:0] delta;
   logic            step;
   logic            valid;
   logic            err;
`ifdef GRAY_PTR_RX_STEP_CNT_EN
   logic [15:0]     step_cnt;
`endif

   always #5 clk = ~clk;

   gray_ptr_rx #(
      .SIZE        (SIZE),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .err_clr   (err_clr),
      .bin_out   (bin_out),
      .gray_sync (gray_sync),
      .delta     (delta),
      .step      (step),
      .valid     (valid),
      .err       (err)
`ifdef GRAY_PTR_RX_STEP_CNT_EN
      ,
      .step_cnt  (step_cnt)
`endif
   );

   typedef struct {
      logic [SIZE-1:0] bin;
      logic [SIZE-1:0] gray;
      logic [SIZE-1:0] dlt;
      logic            stp;
   } acc_t;

   acc_t            sb [$];
   int              total = 0;
   int              bad   = 0;
   int              g2b_tab [NV];
   logic [SIZE-1:0] hist [$];
   logic [SIZE-1:0] cur_g;

   logic            m_valid, m_err, m_step;
   logic [SIZE-1:0] m_bin, m_gray, m_delta;
   int              m_wait;
   int              m_steps = 0;

   function automatic logic [SIZE-1:0] b2g(input int b);
      return SIZE'(b ^ (b >> 1));
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the value seen by the receiver is the input sampled SYNC edges
   // earlier; a baseline is taken SYNC+1 edges after reset or error clear.
   always @(posedge clk) begin
      logic [SIZE-1:0] s_seen;
      int              nb, d, hd;
      if (rst) begin
         hist.delete();
         for (int i = 0; i < SYNC; i++) hist.push_back('0);
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_bin   = '0;
         m_gray  = '0;
         m_delta = '0;
         m_step  = 1'b0;
         m_wait  = SYNC + 1;
         m_steps = 0;
      end else begin
         s_seen = hist[SYNC-1];
         hist.push_front(gray_in);
         void'(hist.pop_back());
         m_step  = 1'b0;
         m_delta = '0;
         if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
               m_gray  = s_seen;
               m_bin   = SIZE'(g2b_tab[s_seen]);
               m_valid = 1'b1;
            end
         end else if (m_err) begin
            if (err_clr) begin
               m_err   = 1'b0;
               m_valid = 1'b0;
               m_wait  = SYNC + 1;
            end
         end else begin
            hd = $countones(s_seen ^ m_gray);
            if (hd == 1) begin
               nb      = g2b_tab[s_seen];
               d       = (nb - int'(m_bin) + NV) % NV;
               m_delta = SIZE'(d);
               m_step  = (d == 1);
               sb.push_back('{bin: SIZE'(nb), gray: s_seen, dlt: SIZE'(d), stp: (d == 1)});
               m_gray  = s_seen;
               m_bin   = SIZE'(nb);
               if (m_step && m_steps < 16'hFFFF) m_steps++;
            end else if (hd > 1) begin
               m_err = 1'b1;
            end
         end
      end
   end

   // Monitor: every acceptance the DUT presents must match the oldest predicted one.
   always @(negedge clk) begin
      acc_t e;
      if (step || (delta != '0)) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_acc: got bin=%0h delta=%0h expected none", bin_out, delta);
         end else begin
            e = sb.pop_front();
            checkValue("acc_bin", 32'(bin_out), 32'(e.bin));
            checkValue("acc_gray", 32'(gray_sync), 32'(e.gray));
            checkValue("acc_delta", 32'(delta), 32'(e.dlt));
            checkValue("acc_step", 32'(step), 32'(e.stp));
         end
      end
   end

   task automatic checkOutput();
      checkValue("valid", 32'(valid), 32'(m_valid));
      checkValue("err", 32'(err), 32'(m_err));
      checkValue("bin_out", 32'(bin_out), 32'(m_bin));
      checkValue("gray_sync", 32'(gray_sync), 32'(m_gray));
      checkValue("step", 32'(step), 32'(m_step));
      checkValue("delta", 32'(delta), 32'(m_delta));
   endtask

   task automatic applyStimulus(input logic [SIZE-1:0] g, input logic clr, input logic r);
      gray_in = g;
      err_clr = clr;
      rst     = r;
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic hold(input int n);
      repeat (n) applyStimulus(cur_g, 1'b0, 1'b0);
   endtask

   task automatic stepBy(input int inc);
      cur_g = b2g((g2b_tab[cur_g] + inc + NV) % NV);
      applyStimulus(cur_g, 1'b0, 1'b0);
   endtask

   initial begin
      int r, i, j;
      for (int b = 0; b < NV; b++) g2b_tab[b2g(b)] = b;
      cur_g   = '0;
      gray_in = '0;
      err_clr = 1'b0;
      rst     = 1'b1;
      @(negedge clk);

      repeat (5) applyStimulus('0, 1'b0, 1'b1);
      checkValue("rst_valid", 32'(valid), 32'd0);
      checkValue("rst_bin", 32'(bin_out), 32'd0);

      applyStimulus('0, 1'b0, 1'b0);
      applyStimulus('0, 1'b0, 1'b0);
      checkValue("valid_early", 32'(valid), 32'd0);
      applyStimulus('0, 1'b0, 1'b0);
      checkValue("valid_rise", 32'(valid), 32'd1);
      checkValue("base_bin", 32'(bin_out), 32'd0);

      cur_g = 4'b0001; applyStimulus(cur_g, 1'b0, 1'b0);
      cur_g = 4'b0011; applyStimulus(cur_g, 1'b0, 1'b0);
      cur_g = 4'b0010; applyStimulus(cur_g, 1'b0, 1'b0);
      checkValue("seq_step1", 32'(step), 32'd1);
      checkValue("seq_bin1", 32'(bin_out), 32'd1);
      hold(1);
      checkValue("seq_bin2", 32'(bin_out), 32'd2);
      hold(1);
      checkValue("seq_step3", 32'(step), 32'd1);
      checkValue("seq_bin3", 32'(bin_out), 32'd3);
      hold(1);
      checkValue("seq_idle", 32'(step), 32'd0);

      repeat (12) stepBy(1);
      hold(3);
      checkValue("at_15", 32'(bin_out), 32'd15);
      stepBy(1);
      hold(SYNC);
      checkValue("wrap_bin", 32'(bin_out), 32'd0);
      checkValue("wrap_delta", 32'(delta), 32'd1);
      checkValue("wrap_step", 32'(step), 32'd1);

      repeat (3) stepBy(1);
      hold(3);
      stepBy(-1);
      hold(SYNC);
      checkValue("dec_bin", 32'(bin_out), 32'd2);
      checkValue("dec_delta", 32'(delta), 32'hF);
      checkValue("dec_step", 32'(step), 32'd0);
      checkValue("dec_err", 32'(err), 32'd0);

      repeat (2) stepBy(-1);
      hold(3);
      cur_g = 4'b0011;
      applyStimulus(cur_g, 1'b0, 1'b0);
      hold(SYNC);
      checkValue("jump_err", 32'(err), 32'd1);
      checkValue("jump_bin", 32'(bin_out), 32'd0);
      hold(2);
      applyStimulus(cur_g, 1'b1, 1'b0);
      checkValue("clr_err", 32'(err), 32'd0);
      checkValue("clr_valid", 32'(valid), 32'd0);
      hold(2);
      checkValue("rebase_early", 32'(valid), 32'd0);
      hold(1);
      checkValue("rebase_valid", 32'(valid), 32'd1);
      checkValue("rebase_bin", 32'(bin_out), 32'd2);

      repeat (3) stepBy(1);
      hold(3);
      checkValue("at_5", 32'(bin_out), 32'd5);
      applyStimulus(cur_g, 1'b0, 1'b1);
      checkValue("mid_rst_valid", 32'(valid), 32'd0);
      checkValue("mid_rst_bin", 32'(bin_out), 32'd0);
      checkValue("mid_rst_gray", 32'(gray_sync), 32'd0);
`ifdef GRAY_PTR_RX_STEP_CNT_EN
      checkValue("mid_rst_cnt", 32'(step_cnt), 32'd0);
`endif
      hold(4);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 40) stepBy(1);
         else if (r < 55) stepBy(-1);
         else if (r < 72) hold(1);
         else if (r < 82) begin
            cur_g = cur_g ^ SIZE'(1 << $urandom_range(0, SIZE-1));
            applyStimulus(cur_g, 1'b0, 1'b0);
         end else if (r < 88) begin
            i = $urandom_range(0, SIZE-1);
            j = (i + 1 + $urandom_range(0, SIZE-2)) % SIZE;
            cur_g = cur_g ^ SIZE'((1 << i) | (1 << j));
            applyStimulus(cur_g, 1'b0, 1'b0);
         end else if (r < 98) applyStimulus(cur_g, 1'b1, 1'b0);
         else applyStimulus(cur_g, 1'b0, 1'b1);
      end

      hold(SYNC + 2);
      #1;
      checkValue("sb_empty", 32'(sb.size()), 32'd0);
`ifdef GRAY_PTR_RX_STEP_CNT_EN
      checkValue("step_cnt", 32'(step_cnt), 32'(m_steps));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
